btn_input: RTL and testbench

BTN_INPUT -- requirements
Module: btn_input

---
 rtl/ddr_pkg.sv | 42 ++++
 rtl/btn_debounce.sv | 73 +++++++
 rtl/btn_input.sv | 148 ++++++++++++++
 tb/tb_btn_input.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Purpose: shared constants and helpers for the arrow-button input path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents:
//   EVT_*            2-bit event codes carried in the event queue
//   DEBOUNCE_DEFAULT default debounce window in clocks (10 ms at 100 MHz)
//   NUM_*, BTN_RST_IDX  button vector layout: arrows at [3:0], game reset at [4]
//   arrow_code()     arrow index -> event code
//   sat_add8()       8-bit saturating add for the drop counter
package ddr_pkg;

  localparam logic [1:0] EVT_UP    = 2'd0;
  localparam logic [1:0] EVT_RIGHT = 2'd1;
  localparam logic [1:0] EVT_DOWN  = 2'd2;
  localparam logic [1:0] EVT_LEFT  = 2'd3;

  localparam int DEBOUNCE_DEFAULT = 1000000;

  localparam int NUM_ARROWS  = 4;
  localparam int NUM_BTNS    = 5;
  localparam int BTN_RST_IDX = 4;

  // Arrow index order matches o_level bit order {left, down, right, up}.
  function automatic logic [1:0] arrow_code(input logic [1:0] idx);
    logic [1:0] code;
    case (idx)
      2'd0:    code = EVT_UP;
      2'd1:    code = EVT_RIGHT;
      2'd2:    code = EVT_DOWN;
      default: code = EVT_LEFT;
    endcase
    return code;
  endfunction

  // Several arrows may drop in the same clock, so the increment is 0..4.
  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [2:0] n);
    logic [8:0] s;
    s = {1'b0, v} + {6'b000000, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: synchronize one raw asynchronous button and debounce it into a clean level.
// Latency: a raw input stable from before edge E moves the level at edge E+DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running, one decision per clock.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   btn_i          raw button, asynchronous to clk_i
//   level_o        debounced level (registered)
//   rise_o         combinational; high in the cycle whose closing edge flips level_o 0->1,
//                  so anything registered from it lines up with the level flip
module btn_debounce
  import ddr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  // The counter never needs to hold more than DEBOUNCE_CYCLES-1.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic          s2;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          flip;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign s2 = sync_q[1];

  // Any clock where the synchronized value agrees with the level restarts
  // the window, so only an uninterrupted disagreement flips the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    flip    = 1'b0;
    if (s2 == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      flip    = 1'b1;
      level_d = s2;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = flip & s2;

endmodule

// File: rtl/btn_input.sv
// Purpose: debounce four arrow buttons plus a game-reset button and queue arrow press events.
// Latency: press-to-event DEBOUNCE_CYCLES+2 edges after the raw input settles; reset pulse at the level flip.
// Backpressure: i_evt_ready stalls the queue; pending presses are held while it is full, a repeat press of an already pending arrow is counted as dropped.
// Ports:
//   clk, rst                    clock and asynchronous active-low reset
//   btn_up/right/down/left      raw active-high arrow buttons
//   btn_rst                     raw active-high game-reset button
//   o_evt_valid/o_evt_code      head of event queue (FWFT), i_evt_ready pops it
//   o_level                     debounced arrow levels {left, down, right, up}
//   o_rst_pulse                 one-clock pulse on a debounced btn_rst press
//   o_drop_cnt                  saturating count of lost arrow presses
module btn_input
  import ddr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_rst,
  output logic       o_evt_valid,
  output logic [1:0] o_evt_code,
  input  logic       i_evt_ready,
  output logic [3:0] o_level,
  output logic       o_rst_pulse,
  output logic [7:0] o_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // ---------------------------------------------------------------------------
  // Debounce all five buttons
  // ---------------------------------------------------------------------------
  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] rise;

  assign raw = {btn_rst, btn_left, btn_down, btn_right, btn_up};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk),
      .rst_ni (rst),
      .btn_i  (raw[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  // Only the press edge of the game-reset button matters; its level has no consumer.
  logic unused_rst_level;
  assign unused_rst_level = level[BTN_RST_IDX];

  // ---------------------------------------------------------------------------
  // Event queue state (pointers carry one wrap bit to tell full from empty)
  // ---------------------------------------------------------------------------
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]  mem_q [FIFO_DEPTH];
  logic        empty, full, push, pop, can_push;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_evt_valid = !empty;
  assign pop         = o_evt_valid && i_evt_ready;
  // A full queue still takes a push when the head leaves in the same clock.
  assign can_push    = !full || pop;

  // ---------------------------------------------------------------------------
  // Pending bits, arbiter, drop counting
  // ---------------------------------------------------------------------------
  logic [NUM_ARROWS-1:0] pend_q, pend_d;
  logic [NUM_ARROWS-1:0] clr;
  logic [NUM_ARROWS-1:0] drop;
  logic [1:0]            sel;
  logic [2:0]            n_drop;
  logic [7:0]            drop_q, drop_d;
  logic                  rst_pulse_q;

  always_comb begin
    // Descending scan so the lowest-index pending arrow wins.
    sel = '0;
    for (int i = NUM_ARROWS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel = 2'(i);
      end
    end

    push = (|pend_q) && can_push;

    clr = '0;
    if (push) begin
      clr[sel] = 1'b1;
    end

    // A press landing on the same clock its pending bit is being pushed
    // simply re-arms the bit; only a press onto a still-held bit is lost.
    pend_d = (pend_q & ~clr) | rise[NUM_ARROWS-1:0];
    drop   = rise[NUM_ARROWS-1:0] & pend_q & ~clr;

    n_drop = '0;
    for (int i = 0; i < NUM_ARROWS; i++) begin
      n_drop = n_drop + {2'b00, drop[i]};
    end
    drop_d = sat_add8(drop_q, n_drop);

    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= '0;
      drop_q      <= '0;
      rst_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      rst_pulse_q <= rise[BTN_RST_IDX];
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= arrow_code(sel);
    end
  end

  // Force the code to zero when empty so stale storage never shows, including under reset.
  assign o_evt_code  = o_evt_valid ? mem_q[rd_ptr_q[AW-1:0]] : 2'b00;
  assign o_level     = level[NUM_ARROWS-1:0];
  assign o_rst_pulse = rst_pulse_q;
  assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_btn_input.sv
module tb_btn_input;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_right, btn_down, btn_left, btn_rst;
  logic       i_evt_ready;
  logic       o_evt_valid;
  logic [1:0] o_evt_code;
  logic [3:0] o_level;
  logic       o_rst_pulse;
  logic [7:0] o_drop_cnt;

  int total = 0;
  int bad   = 0;

  btn_input #(
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_right  (btn_right),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_rst    (btn_rst),
    .o_evt_valid(o_evt_valid),
    .o_evt_code (o_evt_code),
    .i_evt_ready(i_evt_ready),
    .o_level    (o_level),
    .o_rst_pulse(o_rst_pulse),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  // One row per clock edge: inputs driven before the edge, outputs expected just after it.
  typedef struct {
    logic [4:0] btn;   // {rst, left, down, right, up}
    logic       rdy;
    logic [3:0] lvl;
    logic       vld;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] b, input logic r, input int n,
                     input logic [3:0] l, input logic v, input logic [1:0] c);
    vec_t row;
    row.btn = b; row.rdy = r; row.lvl = l; row.vld = v; row.code = c;
    for (int k = 0; k < n; k++) tbl.push_back(row);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_btn(input logic [4:0] b);
    btn_up    = b[0];
    btn_right = b[1];
    btn_down  = b[2];
    btn_left  = b[3];
    btn_rst   = b[4];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_level"}, 32'(o_level), 0);
    chk({nm, "_vld"},   32'(o_evt_valid), 0);
    chk({nm, "_code"},  32'(o_evt_code), 0);
    chk({nm, "_pulse"}, 32'(o_rst_pulse), 0);
    chk({nm, "_drop"},  32'(o_drop_cnt), 0);
  endtask

  task automatic press(input logic [4:0] b, input int hi, input int lo);
    drive_btn(b);
    repeat (hi) tick();
    drive_btn(5'b00000);
    repeat (lo) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, first, pulses, vlds;

    // ---------------- reset state ----------------
    rst = 1'b0;
    drive_btn(5'b00000);
    i_evt_ready = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;

    // ---------------- vector table ----------------
    // single up press, event after edge 6 for one clock; then release
    add(5'b00001, 1, 5, 4'b0000, 0, 0);
    add(5'b00001, 1, 1, 4'b0001, 0, 0);
    add(5'b00001, 1, 1, 4'b0001, 1, 0);
    add(5'b00001, 1, 3, 4'b0001, 0, 0);
    add(5'b00000, 1, 5, 4'b0001, 0, 0);
    add(5'b00000, 1, 2, 4'b0000, 0, 0);
    // 3-clock glitch on right: no effect
    add(5'b00010, 1, 3, 4'b0000, 0, 0);
    add(5'b00000, 1, 8, 4'b0000, 0, 0);
    // up and left together: code 0 then code 3 on consecutive clocks
    add(5'b01001, 1, 5, 4'b0000, 0, 0);
    add(5'b01001, 1, 1, 4'b1001, 0, 0);
    add(5'b01001, 1, 1, 4'b1001, 1, 0);
    add(5'b01001, 1, 1, 4'b1001, 1, 3);
    add(5'b01001, 1, 2, 4'b1001, 0, 0);
    add(5'b00000, 1, 5, 4'b1001, 0, 0);
    add(5'b00000, 1, 2, 4'b0000, 0, 0);

    foreach (tbl[i]) begin
      drive_btn(tbl[i].btn);
      i_evt_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_level", i), 32'(o_level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_vld", i),   32'(o_evt_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_code", i),  32'(o_evt_code), 32'(tbl[i].code));
      chk($sformatf("vec%0d_pulse", i), 32'(o_rst_pulse), 0);
      chk($sformatf("vec%0d_drop", i),  32'(o_drop_cnt), 0);
    end

    // ---------------- queue full, pending held, one drop ----------------
    i_evt_ready = 1'b0;
    for (int p = 0; p < 6; p++) press(5'b00100, 8, 8);
    chk("full_vld",   32'(o_evt_valid), 1);
    chk("full_code",  32'(o_evt_code), 2);
    chk("full_drop",  32'(o_drop_cnt), 1);
    chk("full_level", 32'(o_level), 0);

    // drop counter runs up to and then sticks at 255
    for (int p = 0; p < 253; p++) press(5'b00100, 6, 6);
    chk("drop_254", 32'(o_drop_cnt), 254);
    for (int p = 0; p < 5; p++) press(5'b00100, 6, 6);
    chk("drop_sat", 32'(o_drop_cnt), 255);

    // drain: 4 queued plus the held pending press
    i_evt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_evt_valid) begin
        n++;
        chk($sformatf("drain%0d_code", n), 32'(o_evt_code), 2);
      end
      tick();
    end
    chk("drain_count", 32'(n), 5);
    chk("drain_empty", 32'(o_evt_valid), 0);
    chk("drain_drop",  32'(o_drop_cnt), 255);

    // ---------------- game-reset button ----------------
    drive_btn(5'b10000);
    pulses = 0; vlds = 0; first = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_rst_pulse) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (o_evt_valid) vlds++;
    end
    chk("rstbtn_pulses", 32'(pulses), 1);
    chk("rstbtn_edge",   32'(first), DB + 1);
    chk("rstbtn_novld",  32'(vlds), 0);
    drive_btn(5'b00000);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_rst_pulse) pulses++;
    end
    chk("rstbtn_release_pulses", 32'(pulses), 0);

    // ---------------- reset mid-queue ----------------
    i_evt_ready = 1'b0;
    drive_btn(5'b01000);
    n = 0;
    while (!o_level[3] && n < 20) begin
      tick();
      n++;
    end
    chk("left_flip_seen", 32'(o_level[3]), 1);
    repeat (2) tick();
    chk("left_queued_vld",  32'(o_evt_valid), 1);
    chk("left_queued_code", 32'(o_evt_code), 3);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("arst_now");
    repeat (3) tick();
    chk_all_zero("arst_held");
    rst = 1'b1;
    i_evt_ready = 1'b1;
    n = 0; first = -1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (o_evt_valid) begin
        n++;
        if (first < 0) first = c;
        chk("post_rst_code", 32'(o_evt_code), 3);
      end
    end
    chk("post_rst_count", 32'(n), 1);
    chk("post_rst_edge",  32'(first), DB + 2);
    chk("post_rst_level", 32'(o_level), 4'b1000);
    chk("post_rst_drop",  32'(o_drop_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
